// File: rtl/hlink_pkg.sv
// Shared definitions for the horizontal core-to-core link (transmitter and receiver).
package hlink_pkg;

  // Link/buffer word width is one full MAC row of input activations.
  localparam int MAC_MULT_NUM             = 4;
  localparam int IDATA_WIDTH              = 8;
  localparam int DEFAULT_CACHE_DATA_WIDTH = MAC_MULT_NUM * IDATA_WIDTH;

  // Transmitter sequencing: wait for a command, issue buffer reads, let the last read land.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } hlink_tx_state_e;

endpackage

// File: rtl/hlink_tx.sv
// Horizontal link transmitter: streams a contiguous run of activation-buffer words onto
// the outbound link. The receiver has no backpressure, so all pacing happens here.
// Optional feature macro: HLINK_TX_PAUSE_EN adds the tx_pause port that stalls read issue.
module hlink_tx
  import hlink_pkg::*;
#(
  parameter int CACHE_DATA_WIDTH = DEFAULT_CACHE_DATA_WIDTH,
  parameter int ADDR_WIDTH       = 8,
  parameter int LEN_WIDTH        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_start,
  input  logic [ADDR_WIDTH-1:0]       tx_base_addr,
  input  logic [LEN_WIDTH-1:0]        tx_len,
`ifdef HLINK_TX_PAUSE_EN
  input  logic                        tx_pause,
`endif
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        buf_ren,
  output logic [ADDR_WIDTH-1:0]       buf_raddr,
  input  logic [CACHE_DATA_WIDTH-1:0] buf_rdata,
  output logic [CACHE_DATA_WIDTH-1:0] hlink_wdata,
  output logic                        hlink_wen
);

  hlink_tx_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [LEN_WIDTH-1:0]        rem_q, rem_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        vld_q;
  logic                        wen_q;
  logic [CACHE_DATA_WIDTH-1:0] wdata_q;
  logic                        stall;
  logic                        issue;

`ifdef HLINK_TX_PAUSE_EN
  assign stall = tx_pause;
`else
  assign stall = 1'b0;
`endif

  // A read goes out on every ISSUE cycle that is not stalled.
  assign issue = (state_q == ISSUE) && !stall;

  // Next-state logic: burst capture, address/length stepping and completion.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          if (tx_len != '0) begin
            state_d = ISSUE;
            addr_d  = tx_base_addr;
            rem_d   = tx_len;
          end else begin
            done_d = 1'b1;  // empty burst completes immediately, never busy
          end
        end
      end
      ISSUE: begin
        if (!stall) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;  // keep the last issued address on buf_raddr
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;  // last word reaches the link on the same edge
      end
      default: state_d = IDLE;
    endcase
    // Busy covers the whole burst, including the cycle tx_done is high.
    busy_d = (state_d != IDLE) || (state_q == DRAIN);
  end

  // Control registers: FSM, address and remaining counters, status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Link output register: read data lands one cycle after issue and is forwarded once.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      vld_q <= issue;
      wen_q <= vld_q;
      if (vld_q) begin
        wdata_q <= buf_rdata;
      end
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign buf_ren     = issue;
  assign buf_raddr   = addr_q;
  assign hlink_wdata = wdata_q;
  assign hlink_wen   = wen_q;

endmodule

// File: tb/tb_hlink_tx.sv
// Self-checking bench for hlink_tx: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based behavioural model.
// Builds with or without HLINK_TX_PAUSE_EN.
module tb_hlink_tx;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          tx_start;
  logic [AW-1:0] tx_base_addr;
  logic [LW-1:0] tx_len;
  logic          tx_pause;
  logic          tx_busy;
  logic          tx_done;
  logic          buf_ren;
  logic [AW-1:0] buf_raddr;
  logic [DW-1:0] buf_rdata;
  logic [DW-1:0] hlink_wdata;
  logic          hlink_wen;

  hlink_tx #(.CACHE_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_base_addr (tx_base_addr),
    .tx_len       (tx_len),
`ifdef HLINK_TX_PAUSE_EN
    .tx_pause     (tx_pause),
`endif
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .buf_ren      (buf_ren),
    .buf_raddr    (buf_raddr),
    .buf_rdata    (buf_rdata),
    .hlink_wdata  (hlink_wdata),
    .hlink_wen    (hlink_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pause_eff();
`ifdef HLINK_TX_PAUSE_EN
    return tx_pause;
`else
    return 1'b0;
`endif
  endfunction

  // Activation buffer contents: low byte equals the address, upper bits random.
  logic [DW-1:0] mem [256];

  // ---------------- behavioural model ----------------
  bit            m_valid = 0;
  bit            m_in_burst;
  logic [AW-1:0] m_pend [$];
  logic [AW-1:0] m_last;
  bit            p1_v, p1_last;
  logic [AW-1:0] p1_a;
  bit            m_wen, m_done, m_busy;
  logic [DW-1:0] m_wdata;

  // Advance the model across each clock edge using the inputs held during the ending cycle.
  always @(posedge clk) begin
    bit            rd, lst, fin;
    logic [AW-1:0] a;
    cyc++;
    rd = m_in_burst && (m_pend.size() > 0) && !pause_eff();
    if (rst) begin
      m_valid = 1;  m_in_burst = 0;  m_pend.delete();  m_last = '0;
      p1_v = 0;  p1_last = 0;  p1_a = '0;
      m_wen = 0;  m_done = 0;  m_busy = 0;  m_wdata = '0;
    end else if (m_valid) begin
      fin    = p1_v && p1_last;
      m_wen  = p1_v;
      if (p1_v) m_wdata = mem[p1_a];
      m_done = fin || (!m_in_burst && tx_start && (tx_len == 0));
      lst = 0;
      a   = m_last;
      if (rd) begin
        a      = m_pend.pop_front();
        m_last = a;
        lst    = (m_pend.size() == 0);
      end
      p1_v = rd;  p1_a = a;  p1_last = lst;
      if (fin) m_in_burst = 0;
      else if (!m_in_burst && tx_start && (tx_len != 0)) begin
        m_in_burst = 1;
        for (int i = 0; i < int'(tx_len); i++) m_pend.push_back(AW'(int'(tx_base_addr) + i));
      end
      m_busy = m_in_burst || fin;
    end
  end

  // ---------------- per-cycle compare and logging ----------------
  bit            s_ren;
  logic [AW-1:0] s_raddr;
  int            wcyc [$];
  logic [7:0]    wbyte [$];
  int            dcyc [$];
  int            bcyc [$];
  logic [AW-1:0] ra_log [$];

  always @(negedge clk) begin
    bit            e_ren;
    logic [AW-1:0] e_raddr;
    s_ren   = buf_ren;
    s_raddr = buf_raddr;
    if (m_valid) begin
      e_ren   = m_in_burst && (m_pend.size() > 0) && !pause_eff();
      e_raddr = (m_in_burst && (m_pend.size() > 0)) ? m_pend[0] : m_last;
      check("buf_ren",     buf_ren,     e_ren);
      check("buf_raddr",   buf_raddr,   e_raddr);
      check("hlink_wen",   hlink_wen,   m_wen);
      check("hlink_wdata", hlink_wdata, m_wdata);
      check("tx_done",     tx_done,     m_done);
      check("tx_busy",     tx_busy,     m_busy);
      if (hlink_wen) begin wcyc.push_back(cyc); wbyte.push_back(hlink_wdata[7:0]); end
      if (tx_done) dcyc.push_back(cyc);
      if (tx_busy) bcyc.push_back(cyc);
      if (buf_ren) ra_log.push_back(buf_raddr);
    end
  end

  // ---------------- stimulus helpers ----------------
  // One clock: wait for the edge, then present read data for reads issued in the ended cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      buf_rdata = s_ren ? mem[s_raddr] : DW'($urandom);
    end
  endtask

  task automatic clear_logs();
    wcyc.delete();  wbyte.delete();  dcyc.delete();  bcyc.delete();  ra_log.delete();
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l, output int k);
    clear_logs();
    tx_start = 1'b1;  tx_base_addr = b;  tx_len = l;
    step(1);
    k = cyc;
    tx_start = 1'b0;  tx_base_addr = AW'($urandom);  tx_len = LW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      mem[i] = {r[23:0], 8'(i)};
    end
    rst = 1'b1;  tx_start = 1'b0;  tx_base_addr = '0;  tx_len = '0;  tx_pause = 1'b0;
    buf_rdata = '0;
    step(2);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset buf_raddr", buf_raddr, 8'h00);
    check("reset hlink_wdata", hlink_wdata, 32'h0);
    check("reset tx_busy", tx_busy, 1'b0);

    // Basic burst: base 0x10, len 4.
    start_burst(8'h10, 8'd4, k);
    step(8);
    check("t1 word count", wbyte.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1 word", wbyte[i], 8'h10 + 8'(i));
      check("t1 word cycle", wcyc[i], k + 2 + i);
    end
    check("t1 done count", dcyc.size(), 1);
    check("t1 done cycle", dcyc[0], k + 5);
    check("t1 busy cycles", bcyc.size(), 6);
    check("t1 busy first", bcyc[0], k);
    check("t1 busy last", bcyc[bcyc.size()-1], k + 5);

    // Address wrap: 0xFE, 0xFF, 0x00.
    start_burst(8'hFE, 8'd3, k);
    step(7);
    check("t2 read count", ra_log.size(), 3);
    check("t2 raddr0", ra_log[0], 8'hFE);
    check("t2 raddr1", ra_log[1], 8'hFF);
    check("t2 raddr2", ra_log[2], 8'h00);
    check("t2 word count", wbyte.size(), 3);
    check("t2 word2", wbyte[2], 8'h00);

    // Empty burst.
    start_burst(8'h55, 8'd0, k);
    step(4);
    check("t3 done count", dcyc.size(), 1);
    check("t3 done cycle", dcyc[0], k);
    check("t3 busy cycles", bcyc.size(), 0);
    check("t3 reads", ra_log.size(), 0);
    check("t3 words", wbyte.size(), 0);

`ifdef HLINK_TX_PAUSE_EN
    // Pause for two cycles after the second read of a len-5 burst.
    start_burst(8'h60, 8'd5, k);
    step(2);
    tx_pause = 1'b1;
    step(2);
    tx_pause = 1'b0;
    step(8);
    check("t4 word count", wbyte.size(), 5);
    for (int i = 0; i < 5; i++) check("t4 word", wbyte[i], 8'h60 + 8'(i));
    check("t4 gap before 3rd", wcyc[2] - wcyc[1], 3);
    check("t4 done cycle", dcyc[0], k + 8);
`endif

    // Start pulsed mid-burst is ignored.
    start_burst(8'h20, 8'd6, k);
    step(1);
    tx_start = 1'b1;  tx_base_addr = 8'h80;  tx_len = 8'd2;
    step(1);
    tx_start = 1'b0;
    step(8);
    check("t5 word count", wbyte.size(), 6);
    for (int i = 0; i < 6; i++) check("t5 word", wbyte[i], 8'h20 + 8'(i));
    check("t5 done count", dcyc.size(), 1);
    check("t5 done cycle", dcyc[0], k + 7);

    // Reset after the second word of a len-8 burst, then a fresh burst.
    start_burst(8'h30, 8'd8, k);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk); #1;
    check("t6 ren after rst", buf_ren, 1'b0);
    check("t6 wen after rst", hlink_wen, 1'b0);
    check("t6 busy after rst", tx_busy, 1'b0);
    check("t6 wdata after rst", hlink_wdata, 32'h0);
    step(6);
    check("t6 words before rst", wbyte.size(), 2);
    check("t6 no done", dcyc.size(), 0);
    start_burst(8'h40, 8'd1, k);
    step(4);
    check("t6 fresh count", wbyte.size(), 1);
    check("t6 fresh word", wbyte[0], 8'h40);
    check("t6 fresh cycle", wcyc[0], k + 2);
    check("t6 fresh done", dcyc[0], k + 2);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      tx_start     = ($urandom_range(0, 3) == 0);
      tx_base_addr = AW'($urandom);
      tx_len       = LW'($urandom_range(0, 9));
      tx_pause     = ($urandom_range(0, 3) == 0);
      step(1);
    end
    rst = 1'b0;  tx_start = 1'b0;  tx_pause = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
